// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: opcode values, sequencer state encoding
// and opcode classification helpers used by the control unit and the ALU.
package cpu_ctrl_pkg;

   localparam int unsigned OP_ADD  = 0;
   localparam int unsigned OP_SUB  = 1;
   localparam int unsigned OP_AND  = 2;
   localparam int unsigned OP_OR   = 3;
   localparam int unsigned OP_XOR  = 4;
   localparam int unsigned OP_MUL  = 5;
   localparam int unsigned OP_DIV  = 6;
   localparam int unsigned OP_CMP  = 7;
   localparam int unsigned NUM_OPS = 8;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_WB     = 3'd4
   } ctrl_state_t;

   // Multiply and divide finish asynchronously and report back via alu_done.
   function automatic logic is_multicycle(input int unsigned opcode);
      return (opcode == OP_MUL) || (opcode == OP_DIV);
   endfunction

   // Anything beyond the eight defined operations is rejected in DECODE.
   function automatic logic is_legal(input int unsigned opcode);
      return opcode < NUM_OPS;
   endfunction

endpackage

// File: rtl/alu_wait_timer.sv
// Watchdog for multi-cycle ALU ops: counts WAIT cycles from zero and flags
// the last permitted cycle so the sequencer can abort on a hung ALU.
module alu_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Count enabled cycles; hold at the last value so it never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle instruction sequencer: accepts an instruction over valid/ready,
// walks it through fetch/decode/execute/(wait)/writeback and drives the ALU
// and register-file strobes.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_FETCH  | idle, instr_ready high, latch instr on instr_valid
//   ST_DECODE | publish alu_sel/rd/rs, reject illegal opcodes
//   ST_EXEC   | one-cycle alu_start pulse
//   ST_WAIT   | mul/div in flight, watchdog running
//   ST_WB     | reg_we (or flag_we for cmp), count retired instruction
module seq_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 3,
   parameter int REG_AW   = 2,
   parameter int INSTR_W  = 8,
   parameter int TIMEOUT  = 15,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [INSTR_W-1:0]  instr,
   input  logic                alu_done,
   output logic [OPCODE_W-1:0] alu_sel,
   output logic                alu_start,
   output logic [REG_AW-1:0]   rd_addr,
   output logic [REG_AW-1:0]   rs_addr,
   output logic                reg_we,
   output logic                flag_we,
   output logic                busy,
   output logic                illegal_op,
   output logic                timeout_err,
   output logic [CNT_W-1:0]    retired_cnt
);

   localparam int RD_LSB = INSTR_W - OPCODE_W - REG_AW;
   localparam int RS_LSB = RD_LSB - REG_AW;

   ctrl_state_t         state;
   logic [OPCODE_W-1:0] ir_op;
   logic [REG_AW-1:0]   ir_rd;
   logic [REG_AW-1:0]   ir_rs;

   logic [OPCODE_W-1:0] f_op;
   logic [REG_AW-1:0]   f_rd;
   logic [REG_AW-1:0]   f_rs;

   logic ir_legal;
   logic ir_multi;
   logic ir_cmp;
   logic tmr_clear;
   logic tmr_enable;
   logic tmr_expired;

   assign f_op = instr[INSTR_W-1 -: OPCODE_W];
   assign f_rd = instr[RD_LSB +: REG_AW];
   assign f_rs = instr[RS_LSB +: REG_AW];

   // Spare low instruction bits carry no meaning for the sequencer.
   if (RS_LSB > 0) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^instr[RS_LSB-1:0];
   end

   assign ir_legal = is_legal(32'(ir_op));
   assign ir_multi = is_multicycle(32'(ir_op));
   assign ir_cmp   = (32'(ir_op) == OP_CMP);

   // Counter restarts on every pass through EXEC, so it is zero on WAIT entry.
   assign tmr_clear  = (state != ST_WAIT);
   assign tmr_enable = (state == ST_WAIT);

   alu_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .expired (tmr_expired)
   );

   // Moore strobes for a given state: {instr_ready, busy, alu_start, reg_we, flag_we}.
   // They are loaded together with the state register so they stay pure
   // functions of the current state while coming straight out of flops.
   function automatic logic [4:0] moore_out(input ctrl_state_t s, input logic cmp);
      case (s)
         ST_FETCH: return 5'b10000;
         ST_EXEC:  return 5'b01100;
         ST_WB:    return {3'b010, ~cmp, cmp};
         default:  return 5'b01000;
      endcase
   endfunction

   // Sequencer: state, instruction register, decoded fields, strobes and counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_FETCH;
         ir_op       <= '0;
         ir_rd       <= '0;
         ir_rs       <= '0;
         alu_sel     <= '0;
         rd_addr     <= '0;
         rs_addr     <= '0;
         retired_cnt <= '0;
         illegal_op  <= 1'b0;
         timeout_err <= 1'b0;
         {instr_ready, busy, alu_start, reg_we, flag_we} <= 5'b10000;
      end else begin
         // Error flags are single-cycle: only the aborting transition sets them.
         illegal_op  <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            ST_FETCH: begin
               if (instr_valid) begin
                  ir_op <= f_op;
                  ir_rd <= f_rd;
                  ir_rs <= f_rs;
                  state <= ST_DECODE;
                  {instr_ready, busy, alu_start, reg_we, flag_we} <= moore_out(ST_DECODE, 1'b0);
               end
            end
            ST_DECODE: begin
               alu_sel <= ir_op;
               rd_addr <= ir_rd;
               rs_addr <= ir_rs;
               if (!ir_legal) begin
                  illegal_op <= 1'b1;
                  state      <= ST_FETCH;
                  {instr_ready, busy, alu_start, reg_we, flag_we} <= moore_out(ST_FETCH, 1'b0);
               end else begin
                  state <= ST_EXEC;
                  {instr_ready, busy, alu_start, reg_we, flag_we} <= moore_out(ST_EXEC, 1'b0);
               end
            end
            ST_EXEC: begin
               if (ir_multi) begin
                  state <= ST_WAIT;
                  {instr_ready, busy, alu_start, reg_we, flag_we} <= moore_out(ST_WAIT, 1'b0);
               end else begin
                  state <= ST_WB;
                  {instr_ready, busy, alu_start, reg_we, flag_we} <= moore_out(ST_WB, ir_cmp);
               end
            end
            ST_WAIT: begin
               // A result arriving on the final watchdog cycle still wins.
               if (alu_done) begin
                  state <= ST_WB;
                  {instr_ready, busy, alu_start, reg_we, flag_we} <= moore_out(ST_WB, ir_cmp);
               end else if (tmr_expired) begin
                  timeout_err <= 1'b1;
                  state       <= ST_FETCH;
                  {instr_ready, busy, alu_start, reg_we, flag_we} <= moore_out(ST_FETCH, 1'b0);
               end
            end
            ST_WB: begin
               retired_cnt <= retired_cnt + CNT_W'(1);
               state       <= ST_FETCH;
               {instr_ready, busy, alu_start, reg_we, flag_we} <= moore_out(ST_FETCH, 1'b0);
            end
            default: begin
               state <= ST_FETCH;
               {instr_ready, busy, alu_start, reg_we, flag_we} <= moore_out(ST_FETCH, 1'b0);
            end
         endcase
      end
   end

endmodule

// File: doc/seq_control_unit.md
# seq_control_unit

Multi-cycle, parametrised successor to the combinational opcode-to-ALU-select decoder in the 8-bit CPU. It accepts instructions over a valid/ready handshake and sequences each one through a fetch/decode/execute/writeback FSM. It drives ALU select, ALU start, register-file and flag write enables, and waits on multi-cycle ALU ops (multiply, divide) with a watchdog timeout. It sits between the instruction source and the ALU/register file.

## Interface
- OPCODE_W, 3, opcode field width (≥3)
- REG_AW, 2, register address width
- INSTR_W, 8, instruction width; must be ≥ OPCODE_W+2*REG_AW
- TIMEOUT, 15, max WAIT cycles before abort (≥1)
- CNT_W, 16, retired-instruction counter width

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction available
- instr_ready  out  1  FSM ready to accept
- instr  in  INSTR_W  opcode in MSBs, then rd, then rs; remaining LSBs ignored
- alu_done  in  1  multi-cycle ALU result ready
- alu_sel  out  OPCODE_W  ALU operation select
- alu_start  out  1  one-cycle ALU launch pulse
- rd_addr  out  REG_AW  destination register
- rs_addr  out  REG_AW  source register
- reg_we  out  1  register-file write strobe
- flag_we  out  1  flag-register write strobe (compare)
- busy  out  1  high in every state except FETCH
- illegal_op  out  1  one-cycle error pulse
- timeout_err  out  1  one-cycle error pulse
- retired_cnt  out  CNT_W  count of completed writebacks

## Operation
- Opcodes: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 mul, 6 div, 7 cmp. Opcode values ≥8 (OPCODE_W>3) are illegal.
- States: FETCH, DECODE, EXEC, WAIT, WB.
- FETCH: instr_ready=1. On instr_valid, latch instr into IR and go to DECODE.
- DECODE: register alu_sel, rd_addr and rs_addr from IR.
  - Illegal opcode: set illegal_op and return to FETCH.
  - Otherwise go to EXEC.
- EXEC: alu_start=1. Opcode 5 or 6 goes to WAIT; all others go to WB.
- WAIT: wait counter starts at 0 on entry.
  - alu_done=1 goes to WB.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 with no alu_done, set timeout_err and go to FETCH with no writeback.
- WB: opcode 7 asserts flag_we; all other opcodes assert reg_we. retired_cnt increments and wraps from 2^CNT_W-1 to 0. Then go to FETCH.
- alu_done outside WAIT is ignored.
- Illegal and timed-out instructions do not increment retired_cnt.

## Timing
- Reset values: state FETCH; all 1-bit outputs 0 except instr_ready=1; alu_sel, rd_addr, rs_addr and retired_cnt are 0.
- Reset mid-instruction aborts immediately. No pending reg_we or flag_we is issued.
- instr_ready, alu_start, reg_we, flag_we and busy are Moore outputs decoded from state.
- alu_sel, rd_addr and rs_addr are registered in DECODE and hold until the next DECODE.
- illegal_op and timeout_err are registered. Each is high for exactly the first FETCH cycle after the aborting state.
- Single-cycle op: handshake edge at cycle 0, then DECODE at cycle 1, EXEC at cycle 2, WB at cycle 3, FETCH at cycle 4. Throughput is one instruction per 4 cycles with back-to-back valid.
- Multi-cycle op: if alu_done is high in WAIT cycle k, WB follows at cycle k+1.
- Timeout abort: FETCH is entered exactly TIMEOUT WAIT cycles after EXEC.
- instr is sampled only on the handshake edge. Changes while busy are ignored.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - opcode localparams (OP_ADD … OP_CMP)
  - FSM state encodings
  - the is_multicycle(opcode) function
- The CPU top and ALU reuse the same package.
- One sub-module, alu_wait_timer, contains the WAIT counter with clear/enable/expired signals, parametrised by TIMEOUT.

## Test plan
- Reset, then instr=8'b000_01_10_0 (add) with valid held. Expected:
  - alu_sel=0, rd=1, rs=2
  - alu_start at cycle 2, reg_we at cycle 3, retired_cnt=1
  - instr_ready back high at cycle 4
- Cmp (opcode 7): flag_we=1 and reg_we=0 in WB.
- Div (opcode 6) with alu_done raised 3 cycles after alu_start: WB occurs one cycle after alu_done; busy spans DECODE through WB.
- Mul with alu_done never asserted, TIMEOUT=15: timeout_err pulses once; no reg_we; retired_cnt is unchanged.
- OPCODE_W=4, opcode 9: illegal_op pulses once; no alu_start; FSM returns to FETCH. Separately, CNT_W=2 after 4 adds: retired_cnt wraps to 0.
- Assert rst during WAIT: all outputs immediately take reset values; the next instruction then executes normally.
